// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: parametrised configuration register array with byte-strobed
// writes, registered reads, per-register update pulses, and a W1C status
// register that drives a masked, registered interrupt.
module cfg_reg_bank #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int STAT_IDX  = 15,
  parameter int IRQEN_IDX = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          write_addr,
  input  logic [DATA_W-1:0]          write_data,
  input  logic [DATA_W/8-1:0]        write_strb,
  input  logic                       write_en,
  input  logic [ADDR_W-1:0]          read_addr,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        reg_updated,
  input  logic [DATA_W-1:0]          hw_status_set,
  output logic                       irq
);

  localparam int NUM_BYTES = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   read_data_q;
  logic [DATA_W-1:0]   read_data_d;
  logic                read_valid_q;
  logic                read_valid_d;
  logic [NUM_REGS-1:0] reg_updated_q;
  logic [NUM_REGS-1:0] reg_updated_d;
  logic                irq_q;
  logic                irq_d;

  // Next register state: strobed bus writes, W1C on status, then hardware set (set wins).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      reg_updated_d[i] = 1'b0;
      if (write_en && (write_addr == ADDR_W'(i)) && (|write_strb)) begin
        reg_updated_d[i] = 1'b1;
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (write_strb[b]) begin
            if (i == STAT_IDX) begin
              regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8] & ~write_data[8*b +: 8];
            end else begin
              regs_d[i][8*b +: 8] = write_data[8*b +: 8];
            end
          end else begin
            regs_d[i][8*b +: 8] = regs_q[i][8*b +: 8];
          end
        end
      end else begin
        reg_updated_d[i] = 1'b0;
      end
    end
    // Hardware set is applied last so it overrides a same-cycle clear.
    regs_d[STAT_IDX] = regs_d[STAT_IDX] | hw_status_set;
  end

  // Read path: capture the pre-write value of the addressed register; out-of-range reads return zero.
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = read_en;
    if (read_en) begin
      read_data_d = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        if (read_addr == ADDR_W'(i)) begin
          read_data_d = regs_q[i];
        end else begin
          read_data_d = read_data_d;
        end
      end
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Interrupt is the masked status from the current register contents, registered once.
  always_comb begin
    irq_d = |(regs_q[STAT_IDX] & regs_q[IRQEN_IDX]);
  end

  // State update with synchronous active-high reset overriding all requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      read_data_q   <= {DATA_W{1'b0}};
      read_valid_q  <= 1'b0;
      reg_updated_q <= {NUM_REGS{1'b0}};
      irq_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      read_data_q   <= read_data_d;
      read_valid_q  <= read_valid_d;
      reg_updated_q <= reg_updated_d;
      irq_q         <= irq_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;
  assign reg_updated = reg_updated_q;
  assign irq         = irq_q;

endmodule
